// File: rtl/pc_fetch_unit.sv
// Instruction-fetch / next-PC stage: two-state FETCH/EXEC sequencer holding
// the program counter, the fetched instruction and the retired-instruction
// counter. Branch/jump resolution from execute picks the next PC; misaligned
// taken targets are redirected to the trap vector with a one-cycle pulse.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0040_1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        beq_in,
  input  logic        bne_in,
  input  logic        blt_in,
  input  logic        bge_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        misalign,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] jalr_sum_s;
  logic [31:0] target_s;
  logic        taken_s;
  logic        misalign_s;
  logic [31:0] next_pc_s;

  // Memory request is asserted for the whole FETCH state and always targets pc.
  assign imem_req   = (state_r == FETCH);
  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign jalr_sum_s = rs1_data + imm;

  // Priority-ordered control-transfer resolution: only the highest strobe counts.
  always_comb begin
    target_s = pc + imm;
    taken_s  = 1'b0;
    if (jalr_in) begin
      target_s = jalr_sum_s & ~32'h0000_0001;
      taken_s  = 1'b1;
    end else if (jal_in) begin
      taken_s = 1'b1;
    end else if (beq_in) begin
      taken_s = (rs1_data == rs2_data);
    end else if (bne_in) begin
      taken_s = (rs1_data != rs2_data);
    end else if (blt_in) begin
      taken_s = ($signed(rs1_data) < $signed(rs2_data));
    end else if (bge_in) begin
      taken_s = ($signed(rs1_data) >= $signed(rs2_data));
    end else begin
      taken_s = 1'b0;
    end
  end

  // Next-PC mux: a taken target with low bits set goes to the trap vector.
  always_comb begin
    misalign_s = taken_s && (target_s[1:0] != 2'b00);
    if (misalign_s) begin
      next_pc_s = TRAP_VEC;
    end else if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_plus4;
    end
  end

  // Fetch/execute sequencer with all architectural state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      instret     <= 32'd0;
    end else begin
      misalign <= 1'b0;
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state_r     <= EXEC;
          end
        end
        EXEC: begin
          if (instr_done) begin
            pc          <= next_pc_s;
            instr_valid <= 1'b0;
            instret     <= instret + 32'd1;
            misalign    <= misalign_s;
            state_r     <= FETCH;
          end
        end
        default: begin
          state_r     <= FETCH;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
